// File: rtl/dm_to_dmi_rsp_sync.sv
// dm_to_dmi_rsp_sync
// ------------------
// Carries one debug-module response (data word + error flag) from the core
// clock domain (clk) to the JTAG DTM clock domain (tck_i). A four-phase
// req/ack handshake guards a held data register, so the data bus itself
// is never synchronised bit-wise. Each response is delivered exactly once.
// Only one response is in flight at a time.
//
// Ports
//   clk, rst           core clock, asynchronous active-high reset
//   tck_i, trstn_i     JTAG clock, asynchronous active-low reset
//   rsp_valid_i        clk domain, one-cycle strobe, response available
//   rsp_data_i         clk domain, response data (sampled with rsp_valid_i)
//   rsp_err_i          clk domain, response error flag
//   rsp_ready_o        clk domain, block can accept a response
//   rsp_ovf_o          clk domain, sticky: response strobed while not ready
//   dmi_rsp_valid_o    tck domain, one-cycle pulse per delivered response
//   dmi_rsp_data_o     tck domain, delivered data, held until next delivery
//   dmi_rsp_err_o      tck domain, delivered error, held until next delivery

module dm_to_dmi_rsp_sync #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tck_i,
  input  logic              trstn_i,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  input  logic              rsp_err_i,
  output logic              rsp_ready_o,
  output logic              rsp_ovf_o,
  output logic              dmi_rsp_valid_o,
  output logic [DATA_W-1:0] dmi_rsp_data_o,
  output logic              dmi_rsp_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } clk_state_e;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_ACK  = 1'b1
  } tck_state_e;

  // clk-domain state
  clk_state_e              clk_state_q;
  logic                    req_q;
  logic [DATA_W-1:0]       hold_data_q;
  logic                    hold_err_q;
  logic                    ovf_q;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic [SYNC_STAGES-1:0]  settle_q;
  logic                    ack_sync;
  logic                    settled;
  logic                    ready;
  logic                    accept;

  // tck-domain state
  tck_state_e              tck_state_q;
  logic                    ack_q;
  logic [SYNC_STAGES-1:0]  req_sync_q;
  logic                    req_sync;
  logic                    dmi_valid_q;
  logic [DATA_W-1:0]       dmi_data_q;
  logic                    dmi_err_q;

  // ---------------------------------------------------------------------
  // clk domain
  // ---------------------------------------------------------------------

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign settled  = settle_q[SYNC_STAGES-1];

  // The ack synchroniser restarts at 0 on rst even if the tck side is still
  // holding ack high. settle_q keeps ready low until the chain has been
  // refilled from the live ack, so ready cannot glitch high after a core
  // reset in the middle of a handshake.
  assign ready       = (clk_state_q == IDLE) & settled & ~ack_sync;
  assign accept      = rsp_valid_i & ready;
  assign rsp_ready_o = ready;
  assign rsp_ovf_o   = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_q <= '0;
      settle_q   <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
      settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_state_q <= IDLE;
      req_q       <= 1'b0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      case (clk_state_q)
        IDLE: begin
          if (accept) begin
            hold_data_q <= rsp_data_i;
            hold_err_q  <= rsp_err_i;
            req_q       <= 1'b1;
            clk_state_q <= REQ;
          end
        end
        // hold_q stays frozen here; the tck side samples it during REQ.
        REQ: begin
          if (ack_sync) begin
            req_q       <= 1'b0;
            clk_state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!ack_sync) begin
            clk_state_q <= IDLE;
          end
        end
        default: begin
          req_q       <= 1'b0;
          clk_state_q <= IDLE;
        end
      endcase
    end
  end

  // A strobe that arrives while busy is dropped; remember that it happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (rsp_valid_i && !ready) begin
      ovf_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // tck domain
  // ---------------------------------------------------------------------

  assign req_sync = req_sync_q[SYNC_STAGES-1];

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
    end
  end

  // hold_data_q/hold_err_q are read directly: req_sync can only be high
  // while req_q is high and ack has not yet been returned, so the held
  // word is stable whenever it is captured here.
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tck_state_q <= T_IDLE;
      ack_q       <= 1'b0;
      dmi_valid_q <= 1'b0;
      dmi_data_q  <= '0;
      dmi_err_q   <= 1'b0;
    end else begin
      case (tck_state_q)
        T_IDLE: begin
          if (req_sync) begin
            dmi_data_q  <= hold_data_q;
            dmi_err_q   <= hold_err_q;
            dmi_valid_q <= 1'b1;
            ack_q       <= 1'b1;
            tck_state_q <= T_ACK;
          end else begin
            dmi_valid_q <= 1'b0;
          end
        end
        T_ACK: begin
          dmi_valid_q <= 1'b0;
          if (!req_sync) begin
            ack_q       <= 1'b0;
            tck_state_q <= T_IDLE;
          end
        end
        default: begin
          dmi_valid_q <= 1'b0;
          ack_q       <= 1'b0;
          tck_state_q <= T_IDLE;
        end
      endcase
    end
  end

  assign dmi_rsp_valid_o = dmi_valid_q;
  assign dmi_rsp_data_o  = dmi_data_q;
  assign dmi_rsp_err_o   = dmi_err_q;

endmodule
